// File: rtl/simd_pkg.sv
// Shared types and constants for the SIMD command dispatcher.
// Holds the command, instruction and FSM state encodings used by
// simd_dispatch and the bench.
package simd_pkg;

  localparam int ADDR_W    = 16;
  localparam int CNT_W     = 8;
  localparam int ID_W      = 4;
  localparam int INFO_W    = 2 + CNT_W;
  localparam int PAYLOAD_W = (ADDR_W > INFO_W) ? ADDR_W : INFO_W;

  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [ID_W-1:0]      cmd_id_t;
  typedef logic [PAYLOAD_W-1:0] payload_t;

  // NOP is encoded as zero so an all-zero instruction bus is a harmless NOP.
  typedef enum logic [1:0] {
    INSTR_NOP   = 2'd0,
    INSTR_LD    = 2'd1,
    INSTR_INFO  = 2'd2,
    INSTR_STORE = 2'd3
  } opcode_t;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  typedef struct packed {
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
  } instr_info_t;

  typedef struct packed {
    opcode_t  opcode;
    payload_t payload;
  } instr_t;

  typedef struct packed {
    cmd_id_t          id;
    addr_t            src0;
    addr_t            src1;
    addr_t            dst;
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_REJECT = 4'd1,
    S_EN     = 4'd2,
    S_LD0    = 4'd3,
    S_LD1    = 4'd4,
    S_INFO   = 4'd5,
    S_STORE  = 4'd6,
    S_WAIT   = 4'd7,
    S_ACK    = 4'd8
  } state_t;

  // Zero-extend a shared-memory address onto the instruction payload.
  function automatic payload_t addr_payload(input addr_t a);
    return payload_t'(a);
  endfunction

  // Pack {op, count} into the low bits of the payload.
  function automatic payload_t info_payload(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
    instr_info_t info;
    info.op    = op;
    info.count = cnt;
    return payload_t'(info);
  endfunction

endpackage

// File: rtl/simd_dispatch_cmd_fifo.sv
// cmd_fifo: synchronous pointer FIFO with a registered head.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The head is re-registered from storage, so a freshly written entry shows
// up as o_head_vld one cycle after it is pushed.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_head_vld,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign o_empty = (wptr_q == rptr_q);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && o_head_vld;

  // Pointer and head-valid state.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      o_head_vld <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      // A pop consumes the head; the next entry is re-fetched the cycle after.
      o_head_vld <= !o_empty && !pop_ok;
    end
  end

  // Entry storage and registered head data.
  // NOTE: storage is deliberately not reset; the pointers alone decide what is valid.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= i_data;
    o_head <= mem_q[rptr_q[AW-1:0]];
  end

endmodule

// File: rtl/simd_dispatch.sv
// simd_dispatch: issue stage in front of one SIMD processor.
// Buffers commands in cmd_fifo and walks the processor through
// enable / LD / LD / INFO / STORE, then waits for finish and acknowledges.
// Optional watchdog: define SIMD_DISPATCH_TIMEOUT_EN to bound S_WAIT
// to TIMEOUT cycles and raise a sticky o_timeout.
module simd_dispatch
  import simd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_cmd_valid,
  output logic    o_cmd_ready,
  input  cmd_t    i_cmd,
  output logic    o_proc_en,
  output logic    o_proc_valid,
  output instr_t  o_proc_instr,
  input  logic    i_proc_busy,
  input  logic    i_proc_finish,
  output logic    o_done,
  output cmd_id_t o_done_id,
  output logic    o_done_err,
  output logic    o_idle,
  output logic    o_timeout
);

  state_t state_q;
  state_t state_d;
  cmd_t   head;
  cmd_t   cur_q;
  logic   fifo_full;
  logic   fifo_empty;
  logic   head_vld;
  logic   pop;
  logic   timeout_hit;
  logic   ack_err;

  assign pop = (state_q == S_IDLE) && head_vld && !i_proc_busy;

  cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (i_cmd_valid),
    .i_data    (i_cmd),
    .i_pop     (pop),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_head_vld(head_vld),
    .o_head    (head)
  );

  assign o_cmd_ready = !fifo_full;
  assign o_idle      = fifo_empty && (state_q == S_IDLE);

`ifdef SIMD_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt_q;
  logic          timeout_q;
  logic          ack_err_q;

  // Finish on the last allowed cycle still counts as a clean completion.
  assign timeout_hit = (state_q == S_WAIT) && !i_proc_finish
                       && (wait_cnt_q == TW'(TIMEOUT - 1));

  // Cycle counter for S_WAIT, cleared on the way in from S_STORE.
  always_ff @(posedge i_clk) begin
    if (i_rst)                     wait_cnt_q <= '0;
    else if (state_q == S_STORE)   wait_cnt_q <= '0;
    else if (state_q == S_WAIT)    wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  // Sticky timeout flag and the error status reported with the acknowledge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timeout_q <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      if (timeout_hit)          timeout_q <= 1'b1;
      if (state_q == S_WAIT)    ack_err_q <= timeout_hit;
    end
  end

  assign ack_err   = ack_err_q;
  assign o_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign ack_err     = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Capture the popped command for the duration of its sequence.
  always_ff @(posedge i_clk) begin
    if (pop) cur_q <= head;
  end

  // Next-state logic: one step per cycle except the IDLE and WAIT holds.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (head.count == '0 || head.op == OP_RSVD) state_d = S_REJECT;
          else                                        state_d = S_EN;
        end
      end
      S_REJECT: state_d = S_IDLE;
      S_EN:     state_d = S_LD0;
      S_LD0:    state_d = S_LD1;
      S_LD1:    state_d = S_INFO;
      S_INFO:   state_d = S_STORE;
      S_STORE:  state_d = S_WAIT;
      S_WAIT:   if (i_proc_finish || timeout_hit) state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode: valid is only ever driven in LD/INFO/STORE/ACK.
  always_comb begin
    o_proc_en    = 1'b0;
    o_proc_valid = 1'b0;
    o_proc_instr = '0;
    o_done       = 1'b0;
    o_done_id    = '0;
    o_done_err   = 1'b0;
    unique case (state_q)
      S_REJECT: begin
        o_done     = 1'b1;
        o_done_err = 1'b1;
        o_done_id  = cur_q.id;
      end
      S_EN: o_proc_en = 1'b1;
      S_LD0: begin
        o_proc_valid         = 1'b1;
        o_proc_instr.opcode  = INSTR_LD;
        o_proc_instr.payload = addr_payload(cur_q.src0);
      end
      S_LD1: begin
        o_proc_valid         = 1'b1;
        o_proc_instr.opcode  = INSTR_LD;
        o_proc_instr.payload = addr_payload(cur_q.src1);
      end
      S_INFO: begin
        o_proc_valid         = 1'b1;
        o_proc_instr.opcode  = INSTR_INFO;
        o_proc_instr.payload = info_payload(cur_q.op, cur_q.count);
      end
      S_STORE: begin
        o_proc_valid         = 1'b1;
        o_proc_instr.opcode  = INSTR_STORE;
        o_proc_instr.payload = addr_payload(cur_q.dst);
      end
      S_ACK: begin
        o_proc_valid = 1'b1;
        o_done       = 1'b1;
        o_done_id    = cur_q.id;
        o_done_err   = ack_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_simd_dispatch.sv
// Self-checking bench for simd_dispatch: directed steps with a scoreboard
// of expected processor instructions and completions.
module tb_simd_dispatch;
  import simd_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;

  logic    i_clk = 1'b0;
  logic    i_rst;
  logic    i_cmd_valid;
  logic    o_cmd_ready;
  cmd_t    i_cmd;
  logic    o_proc_en;
  logic    o_proc_valid;
  instr_t  o_proc_instr;
  logic    i_proc_busy;
  logic    i_proc_finish;
  logic    o_done;
  cmd_id_t o_done_id;
  logic    o_done_err;
  logic    o_idle;
  logic    o_timeout;

  always #5 i_clk = ~i_clk;

  simd_dispatch #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd        (i_cmd),
    .o_proc_en    (o_proc_en),
    .o_proc_valid (o_proc_valid),
    .o_proc_instr (o_proc_instr),
    .i_proc_busy  (i_proc_busy),
    .i_proc_finish(i_proc_finish),
    .o_done       (o_done),
    .o_done_id    (o_done_id),
    .o_done_err   (o_done_err),
    .o_idle       (o_idle),
    .o_timeout    (o_timeout)
  );

  typedef struct {
    cmd_id_t id;
    logic    err;
  } done_exp_t;

  done_exp_t done_q[$];
  instr_t    instr_q[$];

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   done_seen = 0;
  logic man_fin   = 1'b0;
  logic auto_fin  = 1'b0;
  logic auto_en   = 1'b0;
  int   fin_dly   = 0;

  assign i_proc_finish = man_fin | auto_fin;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk_cmd(input int id, input int s0, input int s1, input int d,
                                  input logic [1:0] op, input int cnt);
    cmd_t c;
    c.id    = cmd_id_t'(id);
    c.src0  = addr_t'(s0);
    c.src1  = addr_t'(s1);
    c.dst   = addr_t'(d);
    c.op    = op;
    c.count = CNT_W'(cnt);
    return c;
  endfunction

  // Scoreboard push: what the processor and upstream should see for c.
  task automatic exp_cmd(input cmd_t c, input logic ack_err);
    instr_t ins;
    done_exp_t de;
    de.id = c.id;
    if (c.count == 0 || c.op == 2'd3) begin
      de.err = 1'b1;
    end else begin
      ins.opcode = INSTR_LD;    ins.payload = payload_t'(c.src0);         instr_q.push_back(ins);
      ins.opcode = INSTR_LD;    ins.payload = payload_t'(c.src1);         instr_q.push_back(ins);
      ins.opcode = INSTR_INFO;  ins.payload = payload_t'({c.op, c.count}); instr_q.push_back(ins);
      ins.opcode = INSTR_STORE; ins.payload = payload_t'(c.dst);          instr_q.push_back(ins);
      ins.opcode = INSTR_NOP;   ins.payload = '0;                         instr_q.push_back(ins);
      de.err = ack_err;
    end
    done_q.push_back(de);
  endtask

  // Scoreboard pop/compare on every instruction and completion.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_proc_valid) begin
        if (instr_q.size() == 0) check("instr_unexpected", o_proc_valid, 1'b0);
        else                     check("instr", o_proc_instr, instr_q.pop_front());
      end
      if (o_done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", o_done, 1'b0);
        end else begin
          done_exp_t de;
          de = done_q.pop_front();
          check("done_id", o_done_id, de.id);
          check("done_err", o_done_err, de.err);
        end
        done_seen++;
      end
    end
  end

  // Processor stand-in: raise finish a few cycles after STORE, drop on the ack.
  always @(negedge i_clk) begin
    if (o_proc_valid && o_proc_instr.opcode == INSTR_NOP) begin
      auto_fin = 1'b0;
    end else if (auto_en && o_proc_valid && o_proc_instr.opcode == INSTR_STORE) begin
      fin_dly = 3;
    end else if (fin_dly != 0) begin
      fin_dly--;
      if (fin_dly == 0) auto_fin = 1'b1;
    end
  end

  task automatic push(input cmd_t c);
    @(negedge i_clk);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_seen < target && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check("wait_done_budget", done_seen >= target, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, o_cmd_ready, 1'b1);
    check({tag, "_idle"}, o_idle, 1'b1);
    check({tag, "_en"}, o_proc_en, 1'b0);
    check({tag, "_valid"}, o_proc_valid, 1'b0);
    check({tag, "_instr"}, o_proc_instr, '0);
    check({tag, "_done"}, o_done, 1'b0);
    check({tag, "_done_id"}, o_done_id, '0);
    check({tag, "_done_err"}, o_done_err, 1'b0);
    check({tag, "_timeout"}, o_timeout, 1'b0);
  endtask

  initial begin
    cmd_t c;
    int   base;

    i_rst       = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd       = '0;
    i_proc_busy = 1'b0;
    repeat (2) @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst = 1'b0;

    // Single command: exact cycle timing relative to the push edge.
    c = mk_cmd(3, 'h100, 'h200, 'h300, OP_ADD, 5);
    exp_cmd(c, 1'b0);
    push(c);
    check("t1_not_idle", o_idle, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge i_clk);
      check("t1_en", o_proc_en, k == 2);
      check("t1_valid", o_proc_valid, (k >= 3 && k <= 6) || k == 11);
      check("t1_done", o_done, k == 11);
      if (k == 11) check("t1_done_id", o_done_id, 4'd3);
      if (k == 10) man_fin = 1'b1;
    end
    man_fin = 1'b0;
    @(negedge i_clk);
    check("t1_idle_after", o_idle, 1'b1);

    // Rejected command: count == 0.
    c = mk_cmd(7, 'h10, 'h20, 'h30, OP_SUB, 0);
    exp_cmd(c, 1'b1);
    push(c);
    for (int k = 1; k <= 4; k++) begin
      @(negedge i_clk);
      check("t2_en", o_proc_en, 1'b0);
      check("t2_valid", o_proc_valid, 1'b0);
      check("t2_done", o_done, k == 2);
      check("t2_err", o_done_err, k == 2);
      if (k == 2) check("t2_done_id", o_done_id, 4'd7);
    end

    // Rejected command: reserved op.
    base = done_seen;
    c = mk_cmd(9, 'h11, 'h22, 'h33, OP_RSVD, 4);
    exp_cmd(c, 1'b1);
    push(c);
    wait_done(base + 1, 20);

    // Fill the FIFO while the processor never finishes.
    base = done_seen;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      c = mk_cmd(i, 'h1000 + i, 'h2000 + i, 'h3000 + i, 2'(i % 3), i + 1);
      i_cmd_valid = 1'b1;
      i_cmd       = c;
      check("t3_ready_accept", o_cmd_ready, 1'b1);
      exp_cmd(c, 1'b0);
    end
    @(negedge i_clk);
    i_cmd = mk_cmd(5, 'h1005, 'h2005, 'h3005, OP_ADD, 6);
    for (int k = 0; k < 4; k++) begin
      check("t3_ready_full", o_cmd_ready, 1'b0);
      @(negedge i_clk);
    end
    i_cmd_valid = 1'b0;
    auto_en = 1'b1;
    man_fin = 1'b1;
    @(negedge i_clk);
    man_fin = 1'b0;
    wait_done(base + 5, 200);
    check("t3_ready_drained", o_cmd_ready, 1'b1);

    // Processor busy blocks the pop.
    base = done_seen;
    i_proc_busy = 1'b1;
    c = mk_cmd(10, 'h40, 'h50, 'h60, OP_MUL, 8);
    exp_cmd(c, 1'b0);
    push(c);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("t4_en_busy", o_proc_en, 1'b0);
      check("t4_idle_busy", o_idle, 1'b0);
    end
    i_proc_busy = 1'b0;
    @(negedge i_clk);
    check("t4_en_release", o_proc_en, 1'b1);
    wait_done(base + 1, 40);
    auto_en = 1'b0;

    // Reset while waiting for finish, with another command queued.
    c = mk_cmd(11, 'h70, 'h80, 'h90, OP_ADD, 2);
    exp_cmd(c, 1'b0);
    push(c);
    repeat (7) @(negedge i_clk);
    check("t5_in_wait_valid", o_proc_valid, 1'b0);
    c = mk_cmd(12, 'h71, 'h81, 'h91, OP_SUB, 3);
    exp_cmd(c, 1'b0);
    push(c);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_reset_outputs("t5_rst");
    done_q.delete();
    instr_q.delete();
    i_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      check("t5_idle_after", o_idle, 1'b1);
      check("t5_no_done", o_done, 1'b0);
    end

`ifdef SIMD_DISPATCH_TIMEOUT_EN
    // Watchdog: finish never comes.
    begin
      int k;
      c = mk_cmd(13, 'hA0, 'hB0, 'hC0, OP_MUL, 1);
      exp_cmd(c, 1'b1);
      push(c);
      k = 0;
      while (!o_done && k < 60) begin
        @(negedge i_clk);
        k++;
      end
      check("t6_ack_cycle", k, 23);
      check("t6_err", o_done_err, 1'b1);
      check("t6_timeout", o_timeout, 1'b1);
      repeat (5) @(negedge i_clk);
      check("t6_timeout_sticky", o_timeout, 1'b1);
      i_rst = 1'b1;
      @(negedge i_clk);
      check("t6_timeout_cleared", o_timeout, 1'b0);
      i_rst = 1'b0;
    end
`endif

    @(negedge i_clk);
    check("end_idle", o_idle, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
